// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between two byte requesters, the shared UART transmitter
// and the arbiter that multiplexes them.
interface uart_tx_arbiter_if #(
   parameter int DATA_W = 8
);
   logic              req0_valid;
   logic [DATA_W-1:0] req0_data;
   logic              req0_last;
   logic              req0_ready;
   logic              req1_valid;
   logic [DATA_W-1:0] req1_data;
   logic              req1_last;
   logic              req1_ready;
   logic              tx_valid;
   logic [DATA_W-1:0] tx_data;
   logic              tx_ready;
   logic [1:0]        grant;
   logic              busy;
   logic              timeout_err;

   // Requesters and transmitter side.
   modport master (
      output req0_valid, req0_data, req0_last,
      input  req0_ready,
      output req1_valid, req1_data, req1_last,
      input  req1_ready,
      input  tx_valid, tx_data,
      output tx_ready,
      input  grant, busy, timeout_err
   );

   // Arbiter side.
   modport slave (
      input  req0_valid, req0_data, req0_last,
      output req0_ready,
      input  req1_valid, req1_data, req1_last,
      output req1_ready,
      output tx_valid, tx_data,
      input  tx_ready,
      output grant, busy, timeout_err
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-level arbiter giving two byte streams alternating ownership of one
// UART transmitter, with a starvation timeout on a held grant.
module uart_tx_arbiter #(
   parameter int DATA_W         = 8,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input logic             SYSCLK,
   input logic             SYSRESET,
   uart_tx_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OWN0 = 2'b01,
      OWN1 = 2'b10
   } state_t;

   localparam logic [15:0] STARVE_LIMIT = 16'(TIMEOUT_CYCLES - 1);

   state_t            state, state_nxt;
   logic              last_served, last_served_nxt;
   logic [15:0]       starve_cnt, starve_cnt_nxt;
   logic              timeout_q, timeout_nxt;
   logic              own_valid;
   logic [DATA_W-1:0] own_data;
   logic              own_last;
   logic              xfer;

   always_ff @(posedge SYSCLK or posedge SYSRESET) begin
      if (SYSRESET) begin
         state       <= IDLE;
         last_served <= 1'b1;
         starve_cnt  <= '0;
         timeout_q   <= 1'b0;
      end else begin
         state       <= state_nxt;
         last_served <= last_served_nxt;
         starve_cnt  <= starve_cnt_nxt;
         timeout_q   <= timeout_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      last_served_nxt = last_served;
      starve_cnt_nxt  = starve_cnt;
      timeout_nxt     = 1'b0;
      own_valid       = 1'b0;
      own_data        = '0;
      own_last        = 1'b0;

      case (state)
         OWN0: begin
            own_valid = bus.req0_valid;
            own_data  = bus.req0_data;
            own_last  = bus.req0_last;
         end
         OWN1: begin
            own_valid = bus.req1_valid;
            own_data  = bus.req1_data;
            own_last  = bus.req1_last;
         end
         default: ;
      endcase

      xfer = own_valid & bus.tx_ready;

      case (state)
         IDLE: begin
            starve_cnt_nxt = '0;
            // On a tie the requester that did not own the last grant wins.
            if (bus.req0_valid && bus.req1_valid)
               state_nxt = last_served ? OWN0 : OWN1;
            else if (bus.req0_valid)
               state_nxt = OWN0;
            else if (bus.req1_valid)
               state_nxt = OWN1;
         end
         OWN0, OWN1: begin
            if (xfer) begin
               starve_cnt_nxt = '0;
               if (own_last) begin
                  state_nxt       = IDLE;
                  last_served_nxt = (state == OWN1);
               end
            end else if (!own_valid) begin
               // A stalled transmitter is not starvation: only an absent byte counts.
               if (starve_cnt >= STARVE_LIMIT) begin
                  state_nxt       = IDLE;
                  last_served_nxt = (state == OWN1);
                  timeout_nxt     = 1'b1;
                  starve_cnt_nxt  = '0;
               end else begin
                  starve_cnt_nxt = starve_cnt + 16'd1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.grant       = state;
   assign bus.busy        = (state != IDLE);
   assign bus.tx_valid    = own_valid;
   assign bus.tx_data     = own_valid ? own_data : '0;
   assign bus.req0_ready  = (state == OWN0) & bus.tx_ready;
   assign bus.req1_ready  = (state == OWN1) & bus.tx_ready;
   assign bus.timeout_err = timeout_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: tie, back-pressure, timeout, stalled
// last byte, fairness and asynchronous mid-packet reset.
module tb_uart_tx_arbiter;
   logic SYSCLK;
   logic SYSRESET;
   int   checks = 0;
   int   errors = 0;
   int   xfers;
   int   g0;
   int   g1;
   logic [1:0] gexp;
   logic [7:0] bp_d [7];
   logic       bp_r [7];
   logic       bp_l [7];

   uart_tx_arbiter_if #(.DATA_W(8)) bus ();

   uart_tx_arbiter #(.DATA_W(8), .TIMEOUT_CYCLES(8)) dut (
      .SYSCLK  (SYSCLK),
      .SYSRESET(SYSRESET),
      .bus     (bus.slave)
   );

   initial begin
      SYSCLK = 1'b0;
      forever #5 SYSCLK = ~SYSCLK;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic chk_b(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_v(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_g(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_n(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [1:0] g, input logic tv,
                          input logic [7:0] td, input logic r0, input logic r1);
      chk_g({tag, ".grant"}, bus.grant, g);
      chk_b({tag, ".busy"}, bus.busy, |g);
      chk_b({tag, ".tx_valid"}, bus.tx_valid, tv);
      chk_v({tag, ".tx_data"}, bus.tx_data, td);
      chk_b({tag, ".req0_ready"}, bus.req0_ready, r0);
      chk_b({tag, ".req1_ready"}, bus.req1_ready, r1);
   endtask

   task automatic step(input logic v0, input logic [7:0] d0, input logic l0,
                       input logic v1, input logic [7:0] d1, input logic l1,
                       input logic rdy);
      @(negedge SYSCLK);
      bus.req0_valid = v0;
      bus.req0_data  = d0;
      bus.req0_last  = l0;
      bus.req1_valid = v1;
      bus.req1_data  = d1;
      bus.req1_last  = l1;
      bus.tx_ready   = rdy;
      #1;
   endtask

   initial begin
      bp_d = '{8'hC1, 8'hC2, 8'hC2, 8'hC3, 8'hC3, 8'hC4, 8'hC4};
      bp_r = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      bp_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

      SYSRESET       = 1'b1;
      bus.req0_valid = 1'b0;
      bus.req0_data  = 8'h00;
      bus.req0_last  = 1'b0;
      bus.req1_valid = 1'b0;
      bus.req1_data  = 8'h00;
      bus.req1_last  = 1'b0;
      bus.tx_ready   = 1'b0;
      #2;
      chk_out("reset", 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
      chk_b("reset.timeout_err", bus.timeout_err, 1'b0);

      // Tie at reset: both requesters hold 3-byte packets.
      bus.req0_valid = 1'b1;
      bus.req0_data  = 8'hA1;
      bus.req1_valid = 1'b1;
      bus.req1_data  = 8'hB1;
      bus.tx_ready   = 1'b1;
      #1;
      chk_out("reset_held", 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
      @(negedge SYSCLK);
      SYSRESET = 1'b0;
      #1;
      chk_out("tie.idle", 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b1, 8'hA1, 1'b0, 1'b1, 8'hB1, 1'b0, 1'b1);
      chk_out("tie.a1", 2'b01, 1'b1, 8'hA1, 1'b1, 1'b0);
      step(1'b1, 8'hA2, 1'b0, 1'b1, 8'hB1, 1'b0, 1'b1);
      chk_out("tie.a2", 2'b01, 1'b1, 8'hA2, 1'b1, 1'b0);
      step(1'b1, 8'hA3, 1'b1, 1'b1, 8'hB1, 1'b0, 1'b1);
      chk_out("tie.a3", 2'b01, 1'b1, 8'hA3, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b1, 8'hB1, 1'b0, 1'b1);
      chk_out("tie.gap", 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b1, 8'hB1, 1'b0, 1'b1);
      chk_out("tie.b1", 2'b10, 1'b1, 8'hB1, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b1, 8'hB2, 1'b0, 1'b1);
      chk_out("tie.b2", 2'b10, 1'b1, 8'hB2, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b1, 8'hB3, 1'b1, 1'b1);
      chk_out("tie.b3", 2'b10, 1'b1, 8'hB3, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      chk_out("tie.end", 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);

      // Back-pressure: tx_ready toggles while a 4-byte packet drains.
      xfers = 0;
      step(1'b1, 8'hC1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      chk_g("bp.idle", bus.grant, 2'b00);
      for (int i = 0; i < 7; i++) begin
         step(1'b1, bp_d[i], bp_l[i], 1'b0, 8'h00, 1'b0, bp_r[i]);
         chk_out("bp.byte", 2'b01, 1'b1, bp_d[i], bp_r[i], 1'b0);
         chk_b("bp.timeout_err", bus.timeout_err, 1'b0);
         if (bus.tx_valid && bus.tx_ready) xfers++;
      end
      step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      chk_g("bp.end", bus.grant, 2'b00);
      chk_b("bp.end_timeout_err", bus.timeout_err, 1'b0);
      chk_n("bp.xfers", xfers, 4);

      // Timeout: one non-last byte, then req0 goes silent; req1 waits.
      step(1'b1, 8'hD1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      chk_g("to.idle", bus.grant, 2'b00);
      step(1'b1, 8'hD1, 1'b0, 1'b1, 8'hE1, 1'b1, 1'b1);
      chk_out("to.d1", 2'b01, 1'b1, 8'hD1, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 8'h00, 1'b0, 1'b1, 8'hE1, 1'b1, 1'b1);
         chk_g("to.held", bus.grant, 2'b01);
         chk_b("to.quiet", bus.timeout_err, 1'b0);
         chk_b("to.tx_valid", bus.tx_valid, 1'b0);
      end
      step(1'b0, 8'h00, 1'b0, 1'b1, 8'hE1, 1'b1, 1'b1);
      chk_b("to.pulse", bus.timeout_err, 1'b1);
      chk_g("to.revoked", bus.grant, 2'b00);
      step(1'b0, 8'h00, 1'b0, 1'b1, 8'hE1, 1'b1, 1'b1);
      chk_b("to.pulse_end", bus.timeout_err, 1'b0);
      chk_out("to.e1", 2'b10, 1'b1, 8'hE1, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      chk_g("to.end", bus.grant, 2'b00);

      // Last byte stalled far past the timeout limit keeps its grant.
      step(1'b0, 8'h00, 1'b0, 1'b1, 8'hF1, 1'b1, 1'b0);
      chk_g("stall.idle", bus.grant, 2'b00);
      for (int i = 0; i < 30; i++) begin
         step(1'b0, 8'h00, 1'b0, 1'b1, 8'hF1, 1'b1, 1'b0);
         chk_g("stall.grant", bus.grant, 2'b10);
         chk_v("stall.data", bus.tx_data, 8'hF1);
         chk_b("stall.timeout_err", bus.timeout_err, 1'b0);
         chk_b("stall.req1_ready", bus.req1_ready, 1'b0);
      end
      step(1'b0, 8'h00, 1'b0, 1'b1, 8'hF1, 1'b1, 1'b1);
      chk_out("stall.go", 2'b10, 1'b1, 8'hF1, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      chk_g("stall.released", bus.grant, 2'b00);
      chk_b("stall.end_timeout_err", bus.timeout_err, 1'b0);

      // Fairness: continuous 1-byte packets from both sides.
      g0 = 0;
      g1 = 0;
      step(1'b1, 8'h55, 1'b1, 1'b1, 8'hAA, 1'b1, 1'b1);
      chk_g("fair.idle", bus.grant, 2'b00);
      for (int i = 1; i <= 40; i++) begin
         if (i == 40) step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
         else         step(1'b1, 8'h55, 1'b1, 1'b1, 8'hAA, 1'b1, 1'b1);
         gexp = (i % 2 == 0) ? 2'b00 : ((i % 4 == 1) ? 2'b01 : 2'b10);
         chk_g("fair.grant", bus.grant, gexp);
         if (bus.grant == 2'b01) g0++;
         if (bus.grant == 2'b10) g1++;
      end
      chk_n("fair.count0", g0, 10);
      chk_n("fair.count1", g1, 10);

      // Reset mid-packet, with last_served left at 0 beforehand.
      step(1'b1, 8'h11, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
      chk_g("rst.idle", bus.grant, 2'b00);
      step(1'b1, 8'h11, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
      chk_out("rst.pre", 2'b01, 1'b1, 8'h11, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b1, 8'h21, 1'b0, 1'b1);
      chk_g("rst.gap", bus.grant, 2'b00);
      step(1'b0, 8'h00, 1'b0, 1'b1, 8'h21, 1'b0, 1'b1);
      chk_out("rst.g1", 2'b10, 1'b1, 8'h21, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1);
      chk_out("rst.g2", 2'b10, 1'b1, 8'h22, 1'b0, 1'b1);
      #1;
      SYSRESET = 1'b1;
      #1;
      chk_out("rst.async", 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
      chk_b("rst.timeout_err", bus.timeout_err, 1'b0);
      @(negedge SYSCLK);
      chk_out("rst.held", 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
      SYSRESET       = 1'b0;
      bus.req0_valid = 1'b1;
      bus.req0_data  = 8'h31;
      bus.req0_last  = 1'b1;
      bus.req1_valid = 1'b1;
      bus.req1_data  = 8'h21;
      bus.req1_last  = 1'b0;
      #1;
      chk_g("rst.released", bus.grant, 2'b00);
      step(1'b1, 8'h31, 1'b1, 1'b1, 8'h21, 1'b0, 1'b1);
      chk_out("rst.rearb", 2'b01, 1'b1, 8'h31, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b1, 8'h21, 1'b0, 1'b1);
      chk_g("rst.gap2", bus.grant, 2'b00);
      step(1'b0, 8'h00, 1'b0, 1'b1, 8'h21, 1'b0, 1'b1);
      chk_out("rst.req1_again", 2'b10, 1'b1, 8'h21, 1'b0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 The block SHALL provide parameter DATA_W, default 8: byte width of every data path.
REQ-003 The block SHALL provide parameter TIMEOUT_CYCLES, default 1000, legal range 2..65535: starvation limit during a held grant.
REQ-004 Ports SHALL be as follows (name  direction  width  meaning):
- SYSCLK  in  1  system clock; all state is updated on its rising edge.
- SYSRESET  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 (radio RX path) has a byte.
- req0_data  in  DATA_W  requester 0 byte.
- req0_last  in  1  requester 0 byte is the last of its packet.
- req0_ready  out  1  requester 0 byte accepted this cycle.
- req1_valid  in  1  requester 1 (host UART bridge) has a byte.
- req1_data  in  DATA_W  requester 1 byte.
- req1_last  in  1  requester 1 byte is the last of its packet.
- req1_ready  out  1  requester 1 byte accepted this cycle.
- tx_valid  out  1  byte is offered to the shared UART transmitter.
- tx_data  out  DATA_W  byte to the transmitter.
- tx_ready  in  1  transmitter accepts tx_data this cycle.
- grant  out  2  one-hot current owner; 00 means no owner.
- busy  out  1  a grant is held.
- timeout_err  out  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-005 The FSM SHALL have three states: IDLE, OWN0 and OWN1; grant SHALL be 00, 01 and 10 respectively; busy SHALL equal |grant.
REQ-006 In IDLE, if exactly one reqN_valid is high, the FSM SHALL enter OWNn on the next edge.
REQ-007 In IDLE with both valids high, the FSM SHALL grant the requester other than last_served; last_served SHALL reset to 1, so requester 0 wins the first tie.
REQ-008 In OWNn, the outputs SHALL be combinational pass-throughs: tx_valid = reqn_valid, tx_data = reqn_data, reqn_ready = tx_ready.
REQ-009 The non-owner's ready SHALL be 0 in every state.
REQ-010 In IDLE, tx_valid, req0_ready and req1_ready SHALL all be 0.
REQ-011 tx_data SHALL be 0 whenever tx_valid is 0.
REQ-012 A transfer SHALL occur in any cycle with tx_valid and tx_ready both high.
REQ-013 A transfer with reqn_last=1 SHALL release the grant:
- the FSM returns to IDLE on the next edge;
- last_served is set to n.
REQ-014 After a release there SHALL be exactly one IDLE cycle before any new grant is made, so minimum packet-to-packet spacing is one idle cycle.
REQ-015 Latency SHALL be one cycle: the first byte is offered on tx_valid in the cycle after reqn_valid is first sampled high in IDLE.
REQ-016 The grant SHALL be held until the last byte or a timeout; it SHALL NOT be preempted by the other requester.
REQ-017 In OWNn, a 16-bit starve counter SHALL behave as follows:
- increments each cycle reqn_valid=0;
- holds while reqn_valid=1 and tx_ready=0, because transmitter back-pressure is not starvation;
- clears on every transfer and on every entry to OWNn.
REQ-018 When the starve counter reaches TIMEOUT_CYCLES-1 while reqn_valid=0, the block SHALL on that edge:
- pulse timeout_err high for exactly one cycle;
- return to IDLE;
- set last_served to n.
REQ-019 If reqn_valid rises in the same cycle the counter reaches its limit, no timeout SHALL occur, and the counter SHALL clear on the resulting transfer.
REQ-020 A byte with reqn_last=1 that waits under tx_ready=0 SHALL keep the grant until it transfers.
REQ-021 Data SHALL never be duplicated, dropped or reordered within a granted packet.

Reset
REQ-022 While SYSRESET is high, the block SHALL force:
- state IDLE, last_served=1, starve counter 0;
- grant=00, busy=0, timeout_err=0;
- tx_valid=0, tx_data=0, req0_ready=0, req1_ready=0.
REQ-023 Reset asserted mid-packet SHALL abort the packet immediately, without waiting for a clock edge; the interrupted requester SHALL be re-arbitrated from IDLE after reset is released.
REQ-024 The first grant after reset release SHALL follow REQ-006/REQ-007 exactly.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Tie at reset: both valid from cycle 0, 3-byte packets (A1 A2 A3, B1 B2 B3), tx_ready=1 -> tx_data A1 A2 A3, one idle cycle, B1 B2 B3; grant 01 then 00 then 10.
- Back-pressure: req0 4-byte packet, tx_ready toggling 1010... -> each byte held stable until accepted, 4 transfers, no timeout_err.
- Timeout: TIMEOUT_CYCLES=8, req0 sends 1 non-last byte then drops valid -> timeout_err pulses exactly 8 cycles after the transfer; grant 00; a pending req1 is then granted.
- Fairness: both requesters stream continuous 1-byte packets for 20 packets -> grants alternate 01/10 and each requester gets 10.
- Reset mid-packet: SYSRESET asserted asynchronously (between clock edges) during byte 2 of 5 -> all outputs go to their reset values immediately; after release, a fresh arbitration with requester 0 winning the tie.
- Last byte under stall: req1_last=1 with tx_ready=0 for 30 cycles (TIMEOUT_CYCLES=8) -> no timeout_err, and the grant is released only after the transfer.
